// File: rtl/audio_pkg.sv
// Shared defaults and types for the codec ADC capture path.
package audio_pkg;
    localparam int DEFAULT_CH_WIDTH = 16;

    typedef logic [2*DEFAULT_CH_WIDTH-1:0] stereo_word_t;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        SKIP,
        SHIFT,
        HOLD
    } cap_state_t;
endpackage

// File: rtl/audio_adc_capture_sync_fifo.sv
// Small first-word-fall-through FIFO; the head word is visible whenever the FIFO is non-empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    output logic                      full,
    input  logic                      pop,
    output logic [WIDTH-1:0]          pop_data,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (level_reg == (AW+1)'(DEPTH));
    assign empty    = (level_reg == '0);
    assign do_pop   = pop & ~empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign do_push  = push & (~full | do_pop);
    assign level    = level_reg;
    assign pop_data = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + (AW+1)'(1);
                2'b01:   level_reg <= level_reg - (AW+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end
endmodule

// File: rtl/audio_adc_capture.sv
// I2S ADC receiver: oversamples the codec pins, assembles {left,right} words and queues them
// for the recording core on a ready/valid port.
module audio_adc_capture
    import audio_pkg::*;
#(
    parameter int CH_WIDTH    = DEFAULT_CH_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_enable,
    input  logic                          i_aud_bclk,
    input  logic                          i_aud_adclrck,
    input  logic                          i_aud_adcdat,
    output logic [2*CH_WIDTH-1:0]         o_audio_data,
    output logic                          o_audio_valid,
    input  logic                          i_audio_ready,
    output logic                          o_overflow,
    input  logic                          i_clear_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
    localparam int CNT_W = $clog2(CH_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CH_WIDTH - 1);

    logic [2:0] pins;
    logic       bclk_s, lr_s, dat_s;
    assign pins = {i_aud_bclk, i_aud_adclrck, i_aud_adcdat};

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        logic [2:0] q_reg;
        if (gi == 0) begin : g_first
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) q_reg <= '0;
                else          q_reg <= pins;
            end
        end else begin : g_rest
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) q_reg <= '0;
                else          q_reg <= g_sync[gi-1].q_reg;
            end
        end
    end
    assign {bclk_s, lr_s, dat_s} = g_sync[SYNC_STAGES-1].q_reg;

    logic bclk_prev_reg, lr_last_reg;
    logic bclk_rise, lr_fall, lr_rise;
    assign bclk_rise = bclk_s & ~bclk_prev_reg;
    assign lr_fall   = bclk_rise & lr_last_reg & ~lr_s;
    assign lr_rise   = bclk_rise & ~lr_last_reg & lr_s;

    cap_state_t          state_reg, state_next;
    logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [CH_WIDTH-2:0] shift_reg, shift_next;
    logic [CH_WIDTH-1:0] left_reg, left_next, right_reg, right_next;
    logic                chan_reg, chan_next;
    logic [CH_WIDTH-1:0] shift_in;
    logic                push;
    assign shift_in = {shift_reg, dat_s};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bclk_prev_reg <= 1'b0;
            lr_last_reg   <= 1'b0;
            state_reg     <= WAIT_SYNC;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            left_reg      <= '0;
            right_reg     <= '0;
            chan_reg      <= 1'b0;
        end else begin
            bclk_prev_reg <= bclk_s;
            if (bclk_rise) lr_last_reg <= lr_s;
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            left_reg      <= left_next;
            right_reg     <= right_next;
            chan_reg      <= chan_next;
        end
    end

    // The I2S delay bit is the one sampled on the LR-edge rise itself, so SKIP only
    // lasts one clock to rearm the counter; the next BCLK rise carries the MSB.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        left_next    = left_reg;
        right_next   = right_reg;
        chan_next    = chan_reg;
        push         = 1'b0;
        if (!i_enable) begin
            state_next = WAIT_SYNC;
        end else begin
            case (state_reg)
                WAIT_SYNC: begin
                    if (lr_fall) begin
                        chan_next  = 1'b0;
                        state_next = SKIP;
                    end
                end
                SKIP: begin
                    bit_cnt_next = '0;
                    state_next   = (lr_fall || lr_rise) ? WAIT_SYNC : SHIFT;
                end
                SHIFT: begin
                    if (lr_fall || lr_rise) begin
                        state_next = WAIT_SYNC;
                    end else if (bclk_rise) begin
                        shift_next   = shift_in[CH_WIDTH-2:0];
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                        if (bit_cnt_reg == LAST_BIT) begin
                            if (chan_reg) right_next = shift_in;
                            else          left_next  = shift_in;
                            state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (lr_rise) begin
                        chan_next  = 1'b1;
                        state_next = SKIP;
                    end else if (lr_fall) begin
                        push       = chan_reg;
                        chan_next  = 1'b0;
                        state_next = SKIP;
                    end
                end
                default: state_next = WAIT_SYNC;
            endcase
        end
    end

    logic fifo_full, fifo_empty, pop, drop, overflow_reg;
    assign o_audio_valid = ~fifo_empty;
    assign pop           = o_audio_valid & i_audio_ready;
    assign drop          = push & fifo_full & ~pop;
    assign o_overflow    = overflow_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)              overflow_reg <= 1'b0;
        else if (drop)             overflow_reg <= 1'b1;
        else if (i_clear_overflow) overflow_reg <= 1'b0;
    end

    sync_fifo #(
        .WIDTH (2*CH_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (push),
        .push_data ({left_reg, right_reg}),
        .full      (fifo_full),
        .pop       (pop),
        .pop_data  (o_audio_data),
        .empty     (fifo_empty),
        .level     (o_fifo_level)
    );
endmodule
